// File: rtl/riscv_trap_pkg.sv
// Shared definitions for the supervisor trap unit: CSR addresses, CSR op
// encodings, exception cause codes, sstatus bit positions and FSM states.
package riscv_trap_pkg;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_TRAPCNT  = 12'h5C0;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'd2;
  localparam logic [31:0] MEMORY_VIOLATION    = 32'd5;

  localparam int SIE  = 1;
  localparam int SPIE = 5;

  // Only SIE and SPIE exist in sstatus; everything else is hardwired to 0.
  localparam logic [63:0] SSTATUS_MASK = (64'd1 << SIE) | (64'd1 << SPIE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/supervisor_csr_file.sv
// Supervisor trap CSR storage: combinational read mux and illegal decode,
// CSR-instruction write ops, and the hardware updates for trap entry and SRET.
module supervisor_csr_file
  import riscv_trap_pkg::*;
#(
  parameter logic [63:0] RESET_STVEC = 64'h0000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        wr_block_i,
  input  logic        trap_take_i,
  input  logic [31:0] trap_cause_i,
  input  logic [63:0] trap_epc_i,
  input  logic        sret_take_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic [63:0] stvec_o,
  output logic [63:0] sepc_o
);

  logic [63:0] sstatus_q, sstatus_d;
  logic [63:0] stvec_q, stvec_d;
  logic [63:0] sscratch_q, sscratch_d;
  logic [63:0] sepc_q, sepc_d;
  logic [63:0] scause_q, scause_d;
  logic [63:0] trapcnt_q, trapcnt_d;

  logic        addr_known;
  logic        wr_en;
  logic [63:0] op_result;

  always_comb begin
    addr_known  = 1'b1;
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_SSTATUS:  csr_rdata_o = sstatus_q;
      CSR_STVEC:    csr_rdata_o = stvec_q;
      CSR_SSCRATCH: csr_rdata_o = sscratch_q;
      CSR_SEPC:     csr_rdata_o = sepc_q;
      CSR_SCAUSE:   csr_rdata_o = scause_q;
      CSR_TRAPCNT:  csr_rdata_o = trapcnt_q;
      default:      addr_known  = 1'b0;
    endcase
  end

  // Any op other than NONE counts as a write, so it is illegal on trap_count.
  assign csr_illegal_o = csr_en_i &&
                         (!addr_known ||
                          (csr_addr_i == CSR_TRAPCNT && csr_op_i != CSR_OP_NONE));

  assign wr_en = csr_en_i && (csr_op_i != CSR_OP_NONE) && !csr_illegal_o && !wr_block_i;

  always_comb begin
    case (csr_op_i)
      CSR_OP_RW: op_result = csr_wdata_i;
      CSR_OP_RS: op_result = csr_rdata_o | csr_wdata_i;
      CSR_OP_RC: op_result = csr_rdata_o & ~csr_wdata_i;
      default:   op_result = csr_rdata_o;
    endcase
  end

  always_comb begin
    sstatus_d  = sstatus_q;
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    trapcnt_d  = trapcnt_q;

    if (trap_take_i) begin
      sepc_d          = trap_epc_i;
      scause_d        = {32'b0, trap_cause_i};
      sstatus_d[SPIE] = sstatus_q[SIE];
      sstatus_d[SIE]  = 1'b0;
      trapcnt_d       = trapcnt_q + 64'd1;
    end else if (sret_take_i) begin
      sstatus_d[SIE]  = sstatus_q[SPIE];
      sstatus_d[SPIE] = 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
        CSR_SSTATUS:  sstatus_d  = op_result & SSTATUS_MASK;
        CSR_STVEC:    stvec_d    = {op_result[63:2], 2'b00};
        CSR_SSCRATCH: sscratch_d = op_result;
        CSR_SEPC:     sepc_d     = {op_result[63:2], 2'b00};
        CSR_SCAUSE:   scause_d   = {1'b0, op_result[62:0]};
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sstatus_q  <= '0;
      stvec_q    <= RESET_STVEC;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      trapcnt_q  <= '0;
    end else begin
      sstatus_q  <= sstatus_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      trapcnt_q  <= trapcnt_d;
    end
  end

  assign stvec_o = stvec_q;
  assign sepc_o  = sepc_q;

endmodule

// File: rtl/supervisor_trap_unit.sv
// Supervisor trap sequencer: accepts exceptions and SRET, flushes the pipeline
// for FLUSH_CYCLES cycles, then presents a valid/ready redirect to IF.
module supervisor_trap_unit
  import riscv_trap_pkg::*;
#(
  parameter logic [63:0] RESET_STVEC  = 64'h0000_0000_0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [63:0] exc_epc,
  input  logic        sret_valid,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  output logic [63:0] csr_rdata,
  output logic        csr_illegal,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        trap_busy
);

  // Redirect handshake: redirect_valid/redirect_pc are held stable from the
  // first REDIRECT cycle until an edge where redirect_ready is sampled high;
  // that edge completes the transfer and returns the FSM to IDLE.

  trap_state_e state_q;
  logic [3:0]  flush_cnt_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [63:0] target_q;

  logic        trap_take;
  logic        sret_take;
  logic [63:0] stvec_val;
  logic [63:0] sepc_val;

  assign trap_take = (state_q == ST_IDLE) && exc_valid;
  assign sret_take = (state_q == ST_IDLE) && sret_valid && !exc_valid;
  assign trap_busy = (state_q != ST_IDLE);

  supervisor_csr_file #(
    .RESET_STVEC (RESET_STVEC)
  ) u_csr (
    .clk           (clk),
    .reset         (reset),
    .csr_en_i      (csr_en),
    .csr_op_i      (csr_op),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    // SRET also swallows a same-cycle CSR write so sstatus has one writer.
    .wr_block_i    (trap_busy | trap_take | sret_take),
    .trap_take_i   (trap_take),
    .trap_cause_i  (exc_cause),
    .trap_epc_i    (exc_epc),
    .sret_take_i   (sret_take),
    .csr_rdata_o   (csr_rdata),
    .csr_illegal_o (csr_illegal),
    .stvec_o       (stvec_val),
    .sepc_o        (sepc_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      target_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trap_take || sret_take) begin
            state_q     <= ST_FLUSH;
            flush_q     <= 1'b1;
            flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
            target_q    <= trap_take ? stvec_val : sepc_val;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            state_q          <= ST_REDIRECT;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;

endmodule

// File: tb/tb_supervisor_trap_unit.sv
// Directed bench for supervisor_trap_unit: trap entry, SRET, redirect
// backpressure, simultaneous events, CSR edge cases and reset mid-flush.
module tb_supervisor_trap_unit;
  import riscv_trap_pkg::*;

  logic        clk;
  logic        reset;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [63:0] exc_epc;
  logic        sret_valid;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        trap_busy;

  int total = 0;
  int bad   = 0;

  supervisor_trap_unit #(
    .RESET_STVEC  (64'h0000_0000_0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_epc        (exc_epc),
    .sret_valid     (sret_valid),
    .csr_en         (csr_en),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .trap_busy      (trap_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_en   = 1'b1;
    csr_op   = CSR_OP_NONE;
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
    csr_en   = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_en    = 1'b0;
    csr_op    = CSR_OP_NONE;
    csr_wdata = '0;
  endtask

  task automatic pulse_exc(input logic [31:0] cause, input logic [63:0] epc);
    exc_valid = 1'b1;
    exc_cause = cause;
    exc_epc   = epc;
    tick();
    exc_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    exc_valid      = 1'b0;
    exc_cause      = '0;
    exc_epc        = '0;
    sret_valid     = 1'b0;
    csr_en         = 1'b0;
    csr_op         = CSR_OP_NONE;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_flush", {63'b0, flush}, 64'd0);
    chk("rst_rvalid", {63'b0, redirect_valid}, 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_busy", {63'b0, trap_busy}, 64'd0);
    chk_rd("rst_stvec", CSR_STVEC, 64'h100);
    chk_rd("rst_sstatus", CSR_SSTATUS, 64'h0);
    chk_rd("rst_trapcnt", CSR_TRAPCNT, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Illegal-instruction trap
    csr_wr(CSR_OP_RW, CSR_STVEC, 64'h8000_0003);
    chk_rd("stvec_masked", CSR_STVEC, 64'h8000_0000);
    tick();
    csr_wr(CSR_OP_RS, CSR_SSTATUS, 64'h2);
    chk_rd("sstatus_sie", CSR_SSTATUS, 64'h2);
    tick();
    pulse_exc(ILLEGAL_INSTRUCTION, 64'h1004);
    chk("t1_flush_c1", {63'b0, flush}, 64'd1);
    chk("t1_busy_c1", {63'b0, trap_busy}, 64'd1);
    chk("t1_rvalid_c1", {63'b0, redirect_valid}, 64'd0);
    tick();
    chk("t1_flush_c2", {63'b0, flush}, 64'd1);
    tick();
    chk("t1_flush_end", {63'b0, flush}, 64'd0);
    chk("t1_rvalid", {63'b0, redirect_valid}, 64'd1);
    chk("t1_rpc", redirect_pc, 64'h8000_0000);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("t1_rvalid_done", {63'b0, redirect_valid}, 64'd0);
    chk("t1_idle", {63'b0, trap_busy}, 64'd0);
    chk_rd("t1_sepc", CSR_SEPC, 64'h1004);
    chk_rd("t1_scause", CSR_SCAUSE, 64'h2);
    chk_rd("t1_sstatus", CSR_SSTATUS, 64'h20);
    chk_rd("t1_trapcnt", CSR_TRAPCNT, 64'h1);
    tick();

    // SRET return with redirect backpressure
    csr_wr(CSR_OP_RW, CSR_SEPC, 64'h100B);
    chk_rd("sepc_masked", CSR_SEPC, 64'h1008);
    tick();
    sret_valid = 1'b1;
    tick();
    sret_valid = 1'b0;
    chk("sret_flush_c1", {63'b0, flush}, 64'd1);
    tick();
    chk("sret_flush_c2", {63'b0, flush}, 64'd1);
    tick();
    chk("sret_flush_end", {63'b0, flush}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_rvalid_%0d", i), {63'b0, redirect_valid}, 64'd1);
      chk($sformatf("bp_rpc_%0d", i), redirect_pc, 64'h1008);
      tick();
    end
    redirect_ready = 1'b1;
    chk("bp_still_busy", {63'b0, trap_busy}, 64'd1);
    tick();
    redirect_ready = 1'b0;
    chk("bp_idle", {63'b0, trap_busy}, 64'd0);
    chk("bp_rvalid_done", {63'b0, redirect_valid}, 64'd0);
    chk_rd("sret_sstatus", CSR_SSTATUS, 64'h22);
    tick();

    // Simultaneous exception + SRET + CSR write
    exc_valid  = 1'b1;
    exc_cause  = MEMORY_VIOLATION;
    exc_epc    = 64'h2002;
    sret_valid = 1'b1;
    csr_en     = 1'b1;
    csr_op     = CSR_OP_RW;
    csr_addr   = CSR_SSCRATCH;
    csr_wdata  = 64'hAB;
    tick();
    sret_valid = 1'b0;
    csr_en     = 1'b0;
    csr_op     = CSR_OP_NONE;
    chk("sim_flush_c1", {63'b0, flush}, 64'd1);
    // Second exception and CSR write during FLUSH must be ignored
    exc_cause  = ILLEGAL_INSTRUCTION;
    exc_epc    = 64'h3000;
    csr_en     = 1'b1;
    csr_op     = CSR_OP_RW;
    csr_addr   = CSR_SSCRATCH;
    csr_wdata  = 64'h55;
    tick();
    exc_valid  = 1'b0;
    csr_en     = 1'b0;
    csr_op     = CSR_OP_NONE;
    chk("sim_flush_c2", {63'b0, flush}, 64'd1);
    tick();
    chk("sim_rvalid", {63'b0, redirect_valid}, 64'd1);
    chk("sim_rpc_stvec", redirect_pc, 64'h8000_0000);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("sim_idle", {63'b0, trap_busy}, 64'd0);
    chk_rd("sim_sscratch", CSR_SSCRATCH, 64'h0);
    chk_rd("sim_sepc", CSR_SEPC, 64'h2002);
    chk_rd("sim_scause", CSR_SCAUSE, 64'h5);
    chk_rd("sim_trapcnt", CSR_TRAPCNT, 64'h2);
    chk_rd("sim_sstatus", CSR_SSTATUS, 64'h20);
    tick();

    // CSR edge cases
    csr_wr(CSR_OP_RS, CSR_SSTATUS, 64'h2);
    chk_rd("rs_sstatus", CSR_SSTATUS, 64'h22);
    tick();
    csr_wr(CSR_OP_RC, CSR_SSTATUS, 64'h2);
    chk_rd("rc_sstatus", CSR_SSTATUS, 64'h20);
    tick();
    csr_wr(CSR_OP_RW, CSR_SSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_rd("rw_sstatus_mask", CSR_SSTATUS, 64'h22);
    tick();
    csr_wr(CSR_OP_RW, CSR_SSCRATCH, 64'hDEAD_BEEF_0123_4567);
    chk_rd("sscratch_full", CSR_SSCRATCH, 64'hDEAD_BEEF_0123_4567);
    tick();
    csr_wr(CSR_OP_RW, CSR_SCAUSE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_rd("scause_bit63", CSR_SCAUSE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    csr_en    = 1'b1;
    csr_op    = CSR_OP_RW;
    csr_addr  = CSR_TRAPCNT;
    csr_wdata = 64'h55;
    #1;
    chk("trapcnt_wr_illegal", {63'b0, csr_illegal}, 64'd1);
    tick();
    csr_en = 1'b0;
    csr_op = CSR_OP_NONE;
    chk_rd("trapcnt_unchanged", CSR_TRAPCNT, 64'h2);
    chk("trapcnt_rd_legal", {63'b0, csr_illegal}, 64'd0);
    csr_en   = 1'b1;
    csr_op   = CSR_OP_NONE;
    csr_addr = 12'h7FF;
    #1;
    chk("bad_addr_illegal", {63'b0, csr_illegal}, 64'd1);
    chk("bad_addr_rdata", csr_rdata, 64'h0);
    csr_en = 1'b0;
    #1;
    chk("no_en_illegal", {63'b0, csr_illegal}, 64'd0);
    tick();

    // Reset asserted in the first FLUSH cycle
    pulse_exc(MEMORY_VIOLATION, 64'h4000);
    chk("rmf_flush", {63'b0, flush}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmf_flush_async", {63'b0, flush}, 64'd0);
    chk("rmf_rvalid", {63'b0, redirect_valid}, 64'd0);
    chk("rmf_busy", {63'b0, trap_busy}, 64'd0);
    chk_rd("rmf_stvec", CSR_STVEC, 64'h100);
    chk_rd("rmf_trapcnt", CSR_TRAPCNT, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_flush", {63'b0, flush}, 64'd0);
    chk("post_rst_busy", {63'b0, trap_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
